// File: rtl/pe_issue_queue.sv
// pe_issue_queue: FIFO issue buffer and in-flight tracker feeding pe_core_single (optional opcode filter: PE_ISSUE_OPCHECK_EN)
module pe_issue_queue #(
   parameter int DEPTH        = 8,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_opcode,
   input  logic [31:0]              in_op1,
   input  logic [31:0]              in_op2,
   input  logic [31:0]              in_op3,
   output logic [31:0]              pe_opcode,
   output logic [31:0]              pe_op1,
   output logic [31:0]              pe_op2,
   output logic [31:0]              pe_op3,
   output logic                     pe_valid,
   input  logic                     pe_result_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic [3:0]               inflight,
   output logic                     busy,
   output logic [15:0]              drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [3:0]    MAXI = 4'(MAX_INFLIGHT);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t        state;
   logic [127:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          legal;
   logic          wr_en;
   logic          issue;
   logic          retire;

   // in_ready depends only on registered state plus flush/reset; a pop in the same cycle never frees a full queue
   assign in_ready = rst_n && (count < FULL) && (state != DRAIN) && !flush;
   assign push     = in_valid && in_ready;
   assign wr_en    = push && legal;
   assign issue    = (state == RUN) && (count != '0) && (inflight < MAXI) && !flush;
   assign retire   = pe_result_valid && (inflight != 4'd0);
   assign busy     = (count != '0) || (inflight != 4'd0);

`ifdef PE_ISSUE_OPCHECK_EN
   assign legal = (in_opcode[31:25] == 7'b0000001) || (in_opcode[31:25] == 7'b0000010) ||
                  (in_opcode[31:25] == 7'b0010000);

   // illegal packets are accepted on the handshake but only counted, saturating
   always_ff @(posedge clk) begin
      if (!rst_n)
         drop_cnt <= '0;
      else if (push && !legal && drop_cnt != 16'hFFFF)
         drop_cnt <= drop_cnt + 16'd1;
   end
`else
   assign legal    = 1'b1;
   assign drop_cnt = '0;
`endif

   // packet storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= {in_opcode, in_op1, in_op2, in_op3};
   end

   // FSM, pointers, occupancy, in-flight count and registered PE outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         inflight  <= '0;
         pe_valid  <= 1'b0;
         pe_opcode <= '0;
         pe_op1    <= '0;
         pe_op2    <= '0;
         pe_op3    <= '0;
      end else begin
         state    <= flush ? DRAIN :
                     state == DRAIN ? ((inflight == 4'd0) ? IDLE : DRAIN) :
                     enable ? RUN : IDLE;
         inflight <= inflight + 4'(issue) - 4'(retire);
         pe_valid <= issue;
         if (issue)
            {pe_opcode, pe_op1, pe_op2, pe_op3} <= mem[rd_ptr];
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            wr_ptr <= wr_ptr + AW'(wr_en);
            rd_ptr <= rd_ptr + AW'(issue);
            count  <= count + CW'(wr_en) - CW'(issue);
         end
      end
   end
endmodule

// File: tb/tb_pe_issue_queue.sv
// tb_pe_issue_queue: directed vector table plus randomized run against a queue-level reference model
module tb_pe_issue_queue;
   logic        clk = 1'b0;
   logic        rst_n, enable, flush, in_valid, in_ready, pe_valid, pe_result_valid, busy;
   logic [31:0] in_opcode, in_op1, in_op2, in_op3, pe_opcode, pe_op1, pe_op2, pe_op3;
   logic [3:0]  count, inflight;
   logic [15:0] drop_cnt;
   int          errors = 0;
   int          checks = 0;

`ifdef PE_ISSUE_OPCHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   localparam logic [31:0] ADD = 32'h0210_0000;
   localparam logic [31:0] SUB = 32'h0220_0000;
   localparam logic [31:0] MUL = 32'h0230_0000;

   always #5 clk = ~clk;

   pe_issue_queue #(.DEPTH(8), .MAX_INFLIGHT(4)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_op1(in_op1), .in_op2(in_op2), .in_op3(in_op3),
      .pe_opcode(pe_opcode), .pe_op1(pe_op1), .pe_op2(pe_op2), .pe_op3(pe_op3),
      .pe_valid(pe_valid), .pe_result_valid(pe_result_valid),
      .count(count), .inflight(inflight), .busy(busy), .drop_cnt(drop_cnt)
   );

   task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, a, e);
      end
   endtask

   typedef struct {
      logic        rn, en, fl, iv, rv;
      logic [31:0] opc, op1, op2;
      logic        xrdy, xpv;
      logic [31:0] xop1, xop2;
      int          xcnt, xinf, xdrop;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rn, en, fl, iv, rv, input logic [31:0] opc, op1, op2,
                      input logic xrdy, xpv, input logic [31:0] xop1, xop2,
                      input int xcnt, xinf, input int xdrop = 0);
      vec_t v;
      v = '{rn, en, fl, iv, rv, opc, op1, op2, xrdy, xpv, xop1, xop2, xcnt, xinf, xdrop};
      vecs.push_back(v);
   endtask

   task automatic run_vec(input int i, input vec_t v);
      rst_n = v.rn; enable = v.en; flush = v.fl; in_valid = v.iv; pe_result_valid = v.rv;
      in_opcode = v.opc; in_op1 = v.op1; in_op2 = v.op2; in_op3 = v.op1 ^ 32'hFFFF;
      #1 chk($sformatf("tbl%0d_ready", i), 128'(in_ready), 128'(v.xrdy));
      @(negedge clk);
      chk($sformatf("tbl%0d_pv", i), 128'(pe_valid), 128'(v.xpv));
      chk($sformatf("tbl%0d_op1", i), 128'(pe_op1), 128'(v.xop1));
      chk($sformatf("tbl%0d_op2", i), 128'(pe_op2), 128'(v.xop2));
      chk($sformatf("tbl%0d_count", i), 128'(count), 128'(v.xcnt));
      chk($sformatf("tbl%0d_inflight", i), 128'(inflight), 128'(v.xinf));
      chk($sformatf("tbl%0d_busy", i), 128'(busy), 128'(v.xcnt != 0 || v.xinf != 0));
      chk($sformatf("tbl%0d_drop", i), 128'(drop_cnt), 128'(v.xdrop));
   endtask

   logic [127:0] q[$];
   int           mst, minf, mdrop;
   logic         mpv;
   logic [127:0] mdata;

   function automatic bit mlegal(input logic [6:0] c);
      return !CHK || c == 7'b0000001 || c == 7'b0000010 || c == 7'b0010000;
   endfunction

   function automatic bit mrdy(input bit rn, fl);
      return rn && q.size() < 8 && mst != 2 && !fl;
   endfunction

   task automatic model_step(input bit rn, en, fl, iv, rv, input logic [127:0] pkt);
      int  n, oinf;
      bit  push, iss, ret;
      n    = q.size();
      oinf = minf;
      push = iv && mrdy(rn, fl);
      iss  = mst == 1 && n > 0 && minf < 4 && !fl;
      ret  = rv && minf > 0;
      if (!rn) begin
         q.delete(); mst = 0; minf = 0; mdrop = 0; mpv = 1'b0; mdata = '0;
      end else begin
         mpv = iss;
         if (iss) mdata = q.pop_front();
         if (fl) q.delete();
         else if (push) begin
            if (mlegal(pkt[127:121])) q.push_back(pkt);
            else if (mdrop < 65535) mdrop++;
         end
         minf = minf + int'(iss) - int'(ret);
         if (fl) mst = 2;
         else if (mst == 2) mst = (oinf == 0) ? 0 : 2;
         else mst = en ? 1 : 0;
      end
   endtask

   initial begin
      logic [7:0]   hist;
      int           lat;
      bit           r_rn, r_en, r_fl, r_iv, r_rv;
      logic [31:0]  tmp, r_opc, r_op1, r_op2, r_op3;
      logic [6:0]   cls;
      rst_n = 0; enable = 0; flush = 0; in_valid = 0; pe_result_valid = 0;
      in_opcode = 0; in_op1 = 0; in_op2 = 0; in_op3 = 0;
      //   rn en fl iv rv opc  op1  op2  rdy pv xop1 xop2 cnt inf
      add(0, 0, 0, 0, 0, ADD, 0,   0,   0,  0, 0,   0,   0,  0);
      add(1, 1, 0, 0, 0, ADD, 0,   0,   1,  0, 0,   0,   0,  0);
      add(1, 1, 0, 1, 0, ADD, 10,  20,  1,  0, 0,   0,   1,  0);
      add(1, 1, 0, 0, 0, ADD, 0,   0,   1,  1, 10,  20,  0,  1);
      add(1, 1, 0, 0, 1, ADD, 0,   0,   1,  0, 10,  20,  0,  0);
      add(1, 1, 0, 1, 0, ADD, 10,  20,  1,  0, 10,  20,  1,  0);
      add(1, 1, 0, 1, 0, SUB, 50,  20,  1,  1, 10,  20,  1,  1);
      add(1, 1, 0, 1, 1, MUL, 12,  5,   1,  1, 50,  20,  1,  1);
      add(1, 1, 0, 0, 1, ADD, 0,   0,   1,  1, 12,  5,   0,  1);
      add(1, 1, 0, 0, 1, ADD, 0,   0,   1,  0, 12,  5,   0,  0);
      add(1, 0, 0, 0, 0, ADD, 0,   0,   1,  0, 12,  5,   0,  0);
      for (int k = 0; k < 8; k++)
         add(1, 0, 0, 1, 0, ADD, 100 + k, k, 1, 0, 12, 5, k + 1, 0);
      add(1, 0, 0, 1, 0, ADD, 999, 0,   0,  0, 12,  5,   8,  0);
      add(1, 1, 0, 0, 0, ADD, 0,   0,   0,  0, 12,  5,   8,  0);
      add(1, 1, 0, 1, 0, ADD, 999, 0,   0,  1, 100, 0,   7,  1);
      for (int k = 1; k < 8; k++)
         add(1, 1, 0, 0, 1, ADD, 0, 0, 1, 1, 100 + k, k, 7 - k, 1);
      add(1, 1, 0, 0, 1, ADD, 0,   0,   1,  0, 107, 7,   0,  0);
      add(1, 0, 0, 0, 0, ADD, 0,   0,   1,  0, 107, 7,   0,  0);
      for (int k = 0; k < 5; k++)
         add(1, 0, 0, 1, 0, ADD, 200 + k, k, 1, 0, 107, 7, k + 1, 0);
      add(1, 1, 0, 0, 0, ADD, 0,   0,   1,  0, 107, 7,   5,  0);
      add(1, 1, 0, 0, 0, ADD, 0,   0,   1,  1, 200, 0,   4,  1);
      add(1, 1, 1, 1, 0, ADD, 1,   1,   0,  0, 200, 0,   0,  1);
      add(1, 1, 0, 1, 0, ADD, 1,   1,   0,  0, 200, 0,   0,  1);
      add(1, 1, 0, 0, 1, ADD, 0,   0,   0,  0, 200, 0,   0,  0);
      add(1, 0, 0, 0, 0, ADD, 0,   0,   0,  0, 200, 0,   0,  0);
      add(1, 0, 0, 0, 0, ADD, 0,   0,   1,  0, 200, 0,   0,  0);
      add(1, 1, 0, 1, 0, ADD, 300, 1,   1,  0, 200, 0,   1,  0);
      add(0, 1, 0, 0, 1, ADD, 0,   0,   0,  0, 0,   0,   0,  0);
      add(1, 0, 0, 0, 0, ADD, 0,   0,   1,  0, 0,   0,   0,  0);
`ifdef PE_ISSUE_OPCHECK_EN
      add(1, 1, 0, 1, 0, 32'hFE00_0000, 7, 0, 1, 0, 0, 0, 0, 0, 1);
      add(1, 1, 0, 1, 0, 32'h04B0_0000, 25, 0, 1, 0, 0, 0, 1, 0, 1);
      add(1, 1, 0, 0, 0, ADD, 0, 0, 1, 1, 25, 0, 0, 1, 1);
      add(1, 1, 0, 0, 1, ADD, 0, 0, 1, 0, 25, 0, 0, 0, 1);
`endif
      @(negedge clk);
      foreach (vecs[i]) run_vec(i, vecs[i]);

      hist = '0; lat = 1; r_en = 1'b1;
      rst_n = 0; flush = 0; in_valid = 0; pe_result_valid = 0; enable = 1;
      model_step(0, 0, 0, 0, 0, '0);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         chk($sformatf("rnd%0d_pv", i), 128'(pe_valid), 128'(mpv));
         chk($sformatf("rnd%0d_data", i), {pe_opcode, pe_op1, pe_op2, pe_op3}, mdata);
         chk($sformatf("rnd%0d_count", i), 128'(count), 128'(q.size()));
         chk($sformatf("rnd%0d_inflight", i), 128'(inflight), 128'(minf));
         chk($sformatf("rnd%0d_busy", i), 128'(busy), 128'(q.size() != 0 || minf != 0));
         chk($sformatf("rnd%0d_drop", i), 128'(drop_cnt), 128'(mdrop));
         if (i % 250 == 0) lat = $urandom_range(1, 3);
         hist = {hist[6:0], mpv};
         r_rn = ($urandom % 300) != 0;
         if ($urandom % 20 == 0) r_en = !r_en;
         r_fl = ($urandom % 40) == 0;
         r_iv = ($urandom % 10) < 6;
         r_rv = hist[lat] | (($urandom % 16) == 0);
         case ($urandom % 4)
            0: cls = 7'b0000001;
            1: cls = 7'b0000010;
            2: cls = 7'b0010000;
            default: begin tmp = $urandom; cls = tmp[6:0]; end
         endcase
         tmp = $urandom;
         r_opc = {cls, tmp[24:0]};
         r_op1 = $urandom; r_op2 = $urandom; r_op3 = $urandom;
         rst_n = r_rn; enable = r_en; flush = r_fl; in_valid = r_iv; pe_result_valid = r_rv;
         in_opcode = r_opc; in_op1 = r_op1; in_op2 = r_op2; in_op3 = r_op3;
         #1 chk($sformatf("rnd%0d_ready", i), 128'(in_ready), 128'(mrdy(r_rn, r_fl)));
         model_step(r_rn, r_en, r_fl, r_iv, r_rv, {r_opc, r_op1, r_op2, r_op3});
         if (!r_rn) hist = '0;
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
